polyphase_commutator: RTL
=========================

// Module: polyphase_commutator
// PURPOSE
// - Input commutator directly upstream of the polyphase half-band FIR stage.
// - Collects a serial 16-bit sample stream into groups of NUM_PHASES consecutive samples.
// - Presents each group as one parallel word, one lane per polyphase branch.
// - Buffers groups in a small FIFO so the filter can stall without dropping input.
// PARAMETERS
// - DATA_W      16  sample width, two's complement
// - NUM_PHASES  2   samples per output group (polyphase branches); legal range 2..8
// - FIFO_DEPTH  4   output FIFO depth in groups; power of 2, >= 2
// PORTS
// - clk         in   1                     system clock, rising edge
// - reset       in   1                     asynchronous, active-high reset
// - data_in     in   DATA_W                input sample
// - valid_in    in   1                     data_in valid
// - ready_in    out  1                     commutator can accept data_in
// - data_out    out  NUM_PHASES*DATA_W     group; lane p = bits [p*DATA_W +: DATA_W]; lane 0 = oldest sample
// - valid_out   out  1                     data_out valid (FIFO not empty)
// - ready_out   in   1                     FIR stage consumes data_out
// - phase       out  $clog2(NUM_PHASES)    index of the lane the next accepted sample fills
// - overflow    out  1                     sticky: valid_in seen while ready_in low
// - flush       in   1                     pad and emit the partial group (POLY_FLUSH_EN only)
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - phase=0, FIFO empty, valid_out=0, data_out=0, overflow=0; gather register and FIFO storage cleared.
//   - Reset mid-group or mid-stall discards all held samples; no partial group is emitted.
// - Accept: a sample is accepted on a rising edge when valid_in && ready_in.
//   - The accepted sample is written to gather lane 'phase'.
//   - phase increments, wrapping NUM_PHASES-1 -> 0.
// - Group push: an accept with phase==NUM_PHASES-1 pushes {data_in, gather lanes 0..P-2} into the FIFO on the same edge.
// - ready_in = !(phase==NUM_PHASES-1 && fifo_full):
//   - Mid-group samples are accepted even while the FIFO is full.
//   - ready_in has no combinational path from ready_out; a pop and a blocked push in the same cycle do not unblock that cycle.
// - Pop: on an edge with valid_out && ready_out, the FIFO head is retired and data_out shows the next entry.
//   - Simultaneous push and pop with the FIFO neither empty nor full: count unchanged, order preserved.
//   - Push into an empty FIFO: valid_out rises in the cycle after the push edge (latency 1 clk from the last sample of the group).
//   - data_out is held stable while valid_out && !ready_out.
// - overflow sets on any edge with valid_in && !ready_in. It clears only on reset. It is purely diagnostic; no sample is lost because upstream holds its data.
// - FIFO pointers are log2(FIFO_DEPTH)+1 bits with MSB wrap. full and empty are decoded from the pointers, never from a separate counter.
// - No arithmetic on samples; data passes bit-exact.
// CONFIGURATION
// - Macro POLY_FLUSH_EN.
// - When defined:
//   - The flush port exists.
//   - flush sampled high with phase!=0 and FIFO not full: pushes the gather register with lanes phase..P-1 forced to 0, and sets phase=0.
//   - While flush is high, ready_in is low (flush has priority over valid_in).
//   - flush with FIFO full is held pending internally until space exists.
//   - flush with phase==0 is a no-op.
// - When undefined:
//   - No flush port and no pad logic.
//   - A partial group is only ever cleared by reset.
// TESTING
// - Stream 0x0001..0x0008, ready_out=1 -> groups {0x0002,0x0001}..{0x0008,0x0007} (lane1,lane0). valid_out rises 1 clk after each second sample.
// - ready_out=0, 10 samples -> 4 groups queued, 9th accepted, 10th stalled. ready_in=0 on 10th, overflow=1, phase=1.
// - Then ready_out=1 -> 4 groups drained in order. 10th sample accepted 1 clk after the first pop. Fifth group = {s10,s9}.
// - Push and pop on the same edge at FIFO count 2 -> count stays 2, no reorder, valid_out stays 1.
// - Assert reset after sample 0x00AA (phase=1) -> phase=0, valid_out=0, overflow=0; next two samples 0x0011,0x0022 -> {0x0022,0x0011}.
// - POLY_FLUSH_EN, NUM_PHASES=4: samples 0x0101,0x0202 then flush -> group {0,0,0x0202,0x0101}, phase=0. flush at phase 0 -> no push.

Source files
------------

// File: rtl/polyphase_commutator_if.sv
// Handshake bundle for polyphase_commutator: serial sample side and grouped side.
// The flush signal exists only when POLY_FLUSH_EN is defined.
interface polyphase_commutator_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_PHASES = 2
);
  localparam int PW = $clog2(NUM_PHASES);

  logic [DATA_W-1:0]            data_in;
  logic                         valid_in;
  logic                         ready_in;
  logic [NUM_PHASES*DATA_W-1:0] data_out;
  logic                         valid_out;
  logic                         ready_out;
  logic [PW-1:0]                phase;
  logic                         overflow;
`ifdef POLY_FLUSH_EN
  logic                         flush;

  modport slave (
    input  data_in, valid_in, ready_out, flush,
    output ready_in, data_out, valid_out, phase, overflow
  );
  modport master (
    output data_in, valid_in, ready_out, flush,
    input  ready_in, data_out, valid_out, phase, overflow
  );
`else
  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, phase, overflow
  );
  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, phase, overflow
  );
`endif
endinterface

// File: rtl/polyphase_commutator.sv
// Serial-to-parallel commutator feeding the polyphase FIR, with group FIFO.
// Define POLY_FLUSH_EN to add the flush port that pads and emits a partial group.
module polyphase_commutator #(
  parameter int DATA_W     = 16,
  parameter int NUM_PHASES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  polyphase_commutator_if.slave bus
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = NUM_PHASES * DATA_W;
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);

  typedef logic [NUM_PHASES-1:0][DATA_W-1:0] grp_t;

  grp_t          gather_q, gather_d;
  grp_t          grp;
  logic [GW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, last;
  logic          ready, accept, push, pop;
`ifdef POLY_FLUSH_EN
  logic          pend_q, pend_d, do_flush;
`endif

  always_comb begin
    last  = (phase_q == LAST);
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
`ifdef POLY_FLUSH_EN
    // A pending flush freezes the gather register until it is pushed.
    ready    = !(last && full) && !bus.flush && !pend_q;
    do_flush = (bus.flush || pend_q) && (phase_q != '0) && !full;
    pend_d   = pend_q;
`else
    ready    = !(last && full);
`endif
    accept   = bus.valid_in && ready;
    pop      = !empty && bus.ready_out;
    gather_d = gather_q;
    phase_d  = phase_q;
    push     = 1'b0;
    grp      = gather_q;
    ovf_d    = ovf_q | (bus.valid_in && !ready);

    if (accept) begin
      gather_d[phase_q] = bus.data_in;
      phase_d = last ? '0 : phase_q + 1'b1;
      push    = last;
      grp     = gather_d;
    end
`ifdef POLY_FLUSH_EN
    if (do_flush) begin
      push    = 1'b1;
      phase_d = '0;
      pend_d  = 1'b0;
      for (int p = 0; p < NUM_PHASES; p++) begin
        grp[p] = (PW'(p) < phase_q) ? gather_q[p] : '0;
      end
    end else if (bus.flush && (phase_q != '0) && full) begin
      pend_d = 1'b1;
    end
`endif

    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gather_q <= '0;
      phase_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
`ifdef POLY_FLUSH_EN
      pend_q   <= 1'b0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      gather_q <= gather_d;
      phase_q  <= phase_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
`ifdef POLY_FLUSH_EN
      pend_q   <= pend_d;
`endif
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= grp;
      end
    end
  end

  assign bus.ready_in  = ready;
  assign bus.valid_out = !empty;
  assign bus.data_out  = mem_q[rd_q[AW-1:0]];
  assign bus.phase     = phase_q;
  assign bus.overflow  = ovf_q;
endmodule
